pls_seq: RTL and testbench

Segment sequencer for the `pls_gen` step-pulse generator. It accepts motion segments from the command path over a valid/ready handshake: each segment is a step count, a period, a direction and a pause flag. It buffers up to two segments and drives the generator's start/stop/abort controls so that consecutive segments chain with no gap. It also maintains a signed step position and status. It sits between the interpolator command path and one axis `pls_gen` instance.

---
 rtl/pls_seq.sv | 218 +++++++++++++++++++++
 tb/tb_pls_seq.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pls_seq.sv
// Segment sequencer for one pls_gen axis: double-buffers motion segments and
// drives the generator start/stop/abort controls so consecutive segments chain.
`ifndef T_MIN
`define T_MIN 4
`endif
`ifndef T_MAX
`define T_MAX 32'hFFFF_FFFF
`endif

module pls_seq #(
   parameter int unsigned T_MIN = `T_MIN,
   parameter int unsigned T_MAX = `T_MAX
) (
   input  logic        clk,
   input  logic        sclr,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [31:0] cmd_n,
   input  logic [31:0] cmd_T,
   input  logic        cmd_dir,
   input  logic        cmd_pause,
   input  logic        abort_req,
   output logic        gen_start_clk,
   output logic        gen_stop_clk,
   output logic        gen_abort,
   output logic [31:0] gen_T,
   output logic        gen_dir_req,
   output logic        gen_pause_req,
   input  logic        gen_run,
   input  logic        gen_loaded,
   input  logic        gen_start_rdy,
   output logic        busy,
   output logic        seg_done,
   output logic        aborted,
   output logic [31:0] pos,
   output logic [31:0] steps_left,
   output logic [1:0]  dbg_state
);

   // Valid/ready: a segment transfers on any clock edge where cmd_valid and
   // cmd_ready are both high; cmd_valid and the cmd_* fields hold until then.

   if (T_MIN < 4 || T_MAX < T_MIN) begin : g_bad_cfg
      $error("pls_seq: T_MIN must be >= 4 and T_MAX >= T_MIN");
   end

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_RUN       = 2'd1,
      S_STOP_WAIT = 2'd2,
      S_ABORT     = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   logic [31:0] r_act_n, r_act_t, r_nxt_n, r_nxt_t;
   logic        r_act_dir, r_act_pause, r_act_valid;
   logic        r_nxt_dir, r_nxt_pause, r_nxt_valid;
   logic        r_start, r_stop, r_abort, r_seg_done, r_aborted;
   logic [31:0] r_pos;

   logic w_start_d, w_stop_d, w_abort_d, w_aborted_d;
   logic w_load, w_last, w_promote, w_vacate, w_flush;
   logic w_accept, w_zero, w_store, w_to_act;

   assign cmd_ready = !r_nxt_valid && (r_state != S_ABORT);
   assign w_accept  = cmd_valid && cmd_ready;
   assign w_zero    = w_accept && (cmd_n == 32'd0);
   assign w_store   = w_accept && (cmd_n != 32'd0);
   // A segment arriving while act retires without a successor refills act directly.
   assign w_to_act  = w_store && (!r_act_valid || w_vacate);

   always_comb begin
      w_state_nxt = r_state;
      w_start_d   = 1'b0;
      w_stop_d    = 1'b0;
      w_abort_d   = 1'b0;
      w_aborted_d = 1'b0;
      w_load      = 1'b0;
      w_last      = 1'b0;
      w_promote   = 1'b0;
      w_vacate    = 1'b0;
      w_flush     = 1'b0;
      if (abort_req) begin
         w_state_nxt = S_ABORT;
         w_abort_d   = 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (r_act_valid && gen_start_rdy) begin
                  w_start_d   = 1'b1;
                  w_state_nxt = S_RUN;
               end
            end
            S_RUN: begin
               if (gen_loaded) begin
                  w_load = 1'b1;
                  if (r_act_n == 32'd1) begin
                     w_last = 1'b1;
                     if (r_nxt_valid) begin
                        w_promote = 1'b1;
                     end else begin
                        w_vacate    = 1'b1;
                        w_stop_d    = 1'b1;
                        w_state_nxt = S_STOP_WAIT;
                     end
                  end
               end
            end
            S_STOP_WAIT: begin
               // Restarting before the generator winds down keeps run continuous.
               if (r_act_valid && gen_start_rdy) begin
                  w_start_d   = 1'b1;
                  w_state_nxt = S_RUN;
               end else if (!gen_run) begin
                  w_state_nxt = S_IDLE;
               end
            end
            S_ABORT: begin
               if (!gen_run) begin
                  w_flush     = 1'b1;
                  w_aborted_d = 1'b1;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_abort_d = 1'b1;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (sclr) begin
         r_state     <= S_IDLE;
         r_act_n     <= '0;
         r_act_t     <= '0;
         r_act_dir   <= 1'b0;
         r_act_pause <= 1'b0;
         r_act_valid <= 1'b0;
         r_nxt_n     <= '0;
         r_nxt_t     <= '0;
         r_nxt_dir   <= 1'b0;
         r_nxt_pause <= 1'b0;
         r_nxt_valid <= 1'b0;
         r_start     <= 1'b0;
         r_stop      <= 1'b0;
         r_abort     <= 1'b0;
         r_seg_done  <= 1'b0;
         r_aborted   <= 1'b0;
         r_pos       <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_start    <= w_start_d;
         r_stop     <= w_stop_d;
         r_abort    <= w_abort_d;
         r_aborted  <= w_aborted_d;
         r_seg_done <= w_last || w_zero;
         if (w_load) begin
            r_act_n <= r_act_n - 32'd1;
            if (!r_act_pause)
               r_pos <= r_act_dir ? r_pos - 32'd1 : r_pos + 32'd1;
         end
         if (w_flush) begin
            r_act_n     <= '0;
            r_act_t     <= '0;
            r_act_dir   <= 1'b0;
            r_act_pause <= 1'b0;
            r_act_valid <= 1'b0;
            r_nxt_n     <= '0;
            r_nxt_t     <= '0;
            r_nxt_dir   <= 1'b0;
            r_nxt_pause <= 1'b0;
            r_nxt_valid <= 1'b0;
         end else begin
            if (w_promote) begin
               r_act_n     <= r_nxt_n;
               r_act_t     <= r_nxt_t;
               r_act_dir   <= r_nxt_dir;
               r_act_pause <= r_nxt_pause;
               r_nxt_valid <= 1'b0;
            end else if (w_vacate) begin
               r_act_valid <= 1'b0;
            end
            if (w_store) begin
               if (w_to_act) begin
                  r_act_n     <= cmd_n;
                  r_act_t     <= cmd_T;
                  r_act_dir   <= cmd_dir;
                  r_act_pause <= cmd_pause;
                  r_act_valid <= 1'b1;
               end else begin
                  r_nxt_n     <= cmd_n;
                  r_nxt_t     <= cmd_T;
                  r_nxt_dir   <= cmd_dir;
                  r_nxt_pause <= cmd_pause;
                  r_nxt_valid <= 1'b1;
               end
            end
         end
      end
   end

   assign gen_start_clk = r_start;
   assign gen_stop_clk  = r_stop;
   assign gen_abort     = r_abort;
   assign gen_T         = r_act_t;
   assign gen_dir_req   = r_act_dir;
   assign gen_pause_req = r_act_pause;
   assign busy          = (r_state != S_IDLE) || r_act_valid || r_nxt_valid;
   assign seg_done      = r_seg_done;
   assign aborted       = r_aborted;
   assign pos           = r_pos;
   assign steps_left    = r_act_n;
   assign dbg_state     = r_state;

endmodule

// File: tb/tb_pls_seq.sv
// Directed bench for pls_seq with a small behavioural pls_gen model that
// reloads every T clocks, honours stop at the next reload and drops run on abort.
module tb_pls_seq;

   logic        clk = 1'b0;
   logic        sclr = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [31:0] cmd_n = '0;
   logic [31:0] cmd_T = '0;
   logic        cmd_dir = 1'b0;
   logic        cmd_pause = 1'b0;
   logic        abort_req = 1'b0;
   logic        gen_start_clk, gen_stop_clk, gen_abort;
   logic [31:0] gen_T;
   logic        gen_dir_req, gen_pause_req;
   logic        gen_run;
   logic        gen_loaded;
   logic        gen_start_rdy = 1'b1;
   logic        busy, seg_done, aborted;
   logic [31:0] pos, steps_left;
   logic [1:0]  dbg_state;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int t_acc    = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pls_seq dut (
      .clk(clk), .sclr(sclr),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_n(cmd_n), .cmd_T(cmd_T), .cmd_dir(cmd_dir), .cmd_pause(cmd_pause),
      .abort_req(abort_req),
      .gen_start_clk(gen_start_clk), .gen_stop_clk(gen_stop_clk), .gen_abort(gen_abort),
      .gen_T(gen_T), .gen_dir_req(gen_dir_req), .gen_pause_req(gen_pause_req),
      .gen_run(gen_run), .gen_loaded(gen_loaded), .gen_start_rdy(gen_start_rdy),
      .busy(busy), .seg_done(seg_done), .aborted(aborted),
      .pos(pos), .steps_left(steps_left), .dbg_state(dbg_state)
   );

   // Generator model
   logic        g_run = 1'b0;
   logic        g_pend = 1'b0;
   logic [31:0] g_cnt = '0;
   logic        w_pend_eff;
   assign w_pend_eff = g_pend && !gen_start_clk;
   assign gen_loaded = !gen_abort &&
                       ((gen_start_clk && !g_run) || (g_run && g_cnt == 32'd0 && !w_pend_eff));
   assign gen_run    = g_run;

   always @(posedge clk) begin
      if (sclr || gen_abort) begin
         g_run  <= 1'b0;
         g_pend <= 1'b0;
         g_cnt  <= '0;
      end else begin
         if (gen_loaded) begin
            g_run <= 1'b1;
            g_cnt <= gen_T - 32'd1;
         end else if (g_run) begin
            if (g_cnt == 32'd0) g_run <= 1'b0;
            else                g_cnt <= g_cnt - 32'd1;
         end
         if (gen_start_clk)                                  g_pend <= 1'b0;
         else if (gen_stop_clk)                              g_pend <= 1'b1;
         else if (g_run && g_cnt == 32'd0 && !gen_loaded)    g_pend <= 1'b0;
      end
   end

   // Event monitor, sampled mid-cycle
   int          n_loads, n_done, n_start, n_stop, n_abort_hi, n_aborted, n_run_fall;
   int          first_start_cyc, last_stop_cyc, last_done_cyc;
   int          load_q[$];
   logic        pause_q[$];
   logic [31:0] posl_q[$];
   logic        prev_run = 1'b0;

   always @(negedge clk) begin
      if (!sclr) begin
         if (gen_loaded) begin
            n_loads++;
            load_q.push_back(cyc);
            pause_q.push_back(gen_pause_req);
            posl_q.push_back(pos);
         end
         if (seg_done) begin n_done++; last_done_cyc = cyc; end
         if (gen_start_clk) begin
            if (n_start == 0) first_start_cyc = cyc;
            n_start++;
         end
         if (gen_stop_clk) begin n_stop++; last_stop_cyc = cyc; end
         if (gen_abort) n_abort_hi++;
         if (aborted) n_aborted++;
         if (prev_run && !g_run) n_run_fall++;
      end
      prev_run = g_run;
   end

   task automatic clr_mon();
      n_loads = 0; n_done = 0; n_start = 0; n_stop = 0;
      n_abort_hi = 0; n_aborted = 0; n_run_fall = 0;
      first_start_cyc = -1; last_stop_cyc = -1; last_done_cyc = -1;
      load_q.delete(); pause_q.delete(); posl_q.delete();
   endtask

   task automatic send(input logic [31:0] n, input logic [31:0] t, input logic d, input logic p);
      int k;
      bit got;
      cmd_n = n; cmd_T = t; cmd_dir = d; cmd_pause = p; cmd_valid = 1'b1;
      got = 1'b0; k = 0;
      while (!got && k < 400) begin
         @(negedge clk);
         if (cmd_ready) got = 1'b1;
         else k++;
      end
      n_checks++;
      if (!got) begin n_fail++; $display("FAIL send_ready: cmd_ready=%0b, required 1", cmd_ready); end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      t_acc = cyc;
   endtask

   task automatic wait_idle(input string tag);
      int k;
      bit done;
      k = 0; done = 1'b0;
      while (!done && k < 1000) begin
         @(negedge clk);
         if (!busy && !g_run && dbg_state == 2'd0) done = 1'b1;
         else k++;
      end
      n_checks++;
      if (!done) begin n_fail++; $display("FAIL %s_idle_timeout: busy=%0b state=%0d, required idle", tag, busy, dbg_state); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      sclr = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks += 9;
      if (cmd_ready !== 1'b1)     begin n_fail++; $display("FAIL rst_cmd_ready: got %0b required 1", cmd_ready); end
      if (busy !== 1'b0)          begin n_fail++; $display("FAIL rst_busy: got %0b required 0", busy); end
      if (pos !== 32'd0)          begin n_fail++; $display("FAIL rst_pos: got %0d required 0", pos); end
      if (steps_left !== 32'd0)   begin n_fail++; $display("FAIL rst_steps_left: got %0d required 0", steps_left); end
      if ({gen_start_clk, gen_stop_clk, gen_abort} !== 3'b000)
                                  begin n_fail++; $display("FAIL rst_gen_ctl: got %b required 000", {gen_start_clk, gen_stop_clk, gen_abort}); end
      if (gen_T !== 32'd0)        begin n_fail++; $display("FAIL rst_gen_T: got %0d required 0", gen_T); end
      if ({gen_dir_req, gen_pause_req} !== 2'b00)
                                  begin n_fail++; $display("FAIL rst_gen_req: got %b required 00", {gen_dir_req, gen_pause_req}); end
      if ({seg_done, aborted} !== 2'b00)
                                  begin n_fail++; $display("FAIL rst_pulses: got %b required 00", {seg_done, aborted}); end
      if (dbg_state !== 2'd0)     begin n_fail++; $display("FAIL rst_state: got %0d required 0", dbg_state); end
      @(posedge clk); #1;
      sclr = 1'b0;
   endtask

   task automatic test_single();
      clr_mon();
      send(32'd3, 32'd10, 1'b0, 1'b0);
      wait_idle("single");
      n_checks += 8;
      if (n_loads != 3)                  begin n_fail++; $display("FAIL single_loads: got %0d required 3", n_loads); end
      if (n_start != 1)                  begin n_fail++; $display("FAIL single_starts: got %0d required 1", n_start); end
      if (first_start_cyc != t_acc + 1)  begin n_fail++; $display("FAIL single_start_latency: got cycle %0d required %0d", first_start_cyc, t_acc + 1); end
      if (n_stop != 1)                   begin n_fail++; $display("FAIL single_stops: got %0d required 1", n_stop); end
      if (load_q.size() != 3 || last_stop_cyc != load_q[2] + 1)
                                         begin n_fail++; $display("FAIL single_stop_timing: got cycle %0d, loads %0d", last_stop_cyc, load_q.size()); end
      if (n_done != 1)                   begin n_fail++; $display("FAIL single_seg_done: got %0d required 1", n_done); end
      if (pos !== 32'd3)                 begin n_fail++; $display("FAIL single_pos: got %0d required 3", pos); end
      if (steps_left !== 32'd0)          begin n_fail++; $display("FAIL single_steps_left: got %0d required 0", steps_left); end
   endtask

   task automatic test_back_to_back();
      clr_mon();
      send(32'd2, 32'd8, 1'b0, 1'b0);
      send(32'd2, 32'd12, 1'b1, 1'b0);
      wait_idle("b2b");
      n_checks += 6;
      if (n_loads != 4) begin n_fail++; $display("FAIL b2b_loads: got %0d required 4", n_loads); end
      if (load_q.size() != 4 || load_q[1] - load_q[0] != 8 || load_q[2] - load_q[1] != 8 || load_q[3] - load_q[2] != 12)
                        begin n_fail++; $display("FAIL b2b_spacing: got %0d loads, required spacing 8,8,12", load_q.size()); end
      if (n_stop != 1)  begin n_fail++; $display("FAIL b2b_stops: got %0d required 1", n_stop); end
      if (n_start != 1) begin n_fail++; $display("FAIL b2b_starts: got %0d required 1", n_start); end
      if (n_done != 2)  begin n_fail++; $display("FAIL b2b_seg_done: got %0d required 2", n_done); end
      if (pos !== 32'd3) begin n_fail++; $display("FAIL b2b_pos: got %0d required 3", pos); end
   endtask

   task automatic test_pause();
      logic [3:0]   pv;
      logic [127:0] pl;
      clr_mon();
      send(32'd1, 32'd8, 1'b0, 1'b0);
      send(32'd2, 32'd20, 1'b0, 1'b1);
      send(32'd1, 32'd8, 1'b0, 1'b0);
      wait_idle("pause");
      pv = 4'hF; pl = '1;
      if (load_q.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            pv[i] = pause_q[i];
            pl[i*32 +: 32] = posl_q[i];
         end
      end
      n_checks += 6;
      if (n_loads != 4)     begin n_fail++; $display("FAIL pause_loads: got %0d required 4", n_loads); end
      if (pv !== 4'b0110)   begin n_fail++; $display("FAIL pause_req_per_load: got %b required 0110", pv); end
      if (pl !== {32'd4, 32'd4, 32'd4, 32'd3})
                            begin n_fail++; $display("FAIL pause_pos_at_loads: got %h required 4,4,4,3", pl); end
      if (pos !== 32'd5)    begin n_fail++; $display("FAIL pause_pos: got %0d required 5", pos); end
      if (n_done != 3)      begin n_fail++; $display("FAIL pause_seg_done: got %0d required 3", n_done); end
      if (n_stop != 1)      begin n_fail++; $display("FAIL pause_stops: got %0d required 1", n_stop); end
   endtask

   task automatic test_abort();
      int k;
      clr_mon();
      send(32'd10, 32'd10, 1'b0, 1'b0);
      send(32'd5, 32'd10, 1'b1, 1'b0);
      k = 0;
      while (n_loads < 3 && k < 200) begin @(posedge clk); k++; end
      #1;
      n_checks++;
      if (n_loads < 3) begin n_fail++; $display("FAIL abort_setup_timeout: got %0d loads required 3", n_loads); end
      abort_req = 1'b1;
      @(posedge clk); #1;
      abort_req = 1'b0;
      @(negedge clk);
      n_checks += 3;
      if (gen_abort !== 1'b1) begin n_fail++; $display("FAIL abort_gen_abort: got %0b required 1", gen_abort); end
      if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL abort_cmd_ready: got %0b required 0", cmd_ready); end
      if (dbg_state !== 2'd3) begin n_fail++; $display("FAIL abort_state: got %0d required 3", dbg_state); end
      wait_idle("abort");
      n_checks += 8;
      if (n_aborted != 1)       begin n_fail++; $display("FAIL abort_pulses: got %0d required 1", n_aborted); end
      if (n_abort_hi != 2)      begin n_fail++; $display("FAIL abort_hold: got %0d cycles required 2", n_abort_hi); end
      if (n_done != 0)          begin n_fail++; $display("FAIL abort_seg_done: got %0d required 0", n_done); end
      if (n_loads != 3)         begin n_fail++; $display("FAIL abort_loads: got %0d required 3", n_loads); end
      if (pos !== 32'd8)        begin n_fail++; $display("FAIL abort_pos: got %0d required 8", pos); end
      if (steps_left !== 32'd0) begin n_fail++; $display("FAIL abort_steps_left: got %0d required 0", steps_left); end
      if (gen_T !== 32'd0)      begin n_fail++; $display("FAIL abort_act_cleared: got T %0d required 0", gen_T); end
      if (cmd_ready !== 1'b1 || gen_abort !== 1'b0)
                                begin n_fail++; $display("FAIL abort_exit: got ready %0b abort %0b required 1 0", cmd_ready, gen_abort); end
   endtask

   task automatic test_zero();
      clr_mon();
      send(32'd0, 32'd10, 1'b0, 1'b0);
      repeat (6) @(posedge clk);
      #1;
      n_checks += 5;
      if (n_done != 1)              begin n_fail++; $display("FAIL zero_seg_done: got %0d required 1", n_done); end
      if (last_done_cyc != t_acc)   begin n_fail++; $display("FAIL zero_done_timing: got cycle %0d required %0d", last_done_cyc, t_acc); end
      if (n_start != 0)             begin n_fail++; $display("FAIL zero_start: got %0d required 0", n_start); end
      if (busy !== 1'b0)            begin n_fail++; $display("FAIL zero_busy: got %0b required 0", busy); end
      if (pos !== 32'd8)            begin n_fail++; $display("FAIL zero_pos: got %0d required 8", pos); end
   endtask

   task automatic test_restart();
      int k;
      clr_mon();
      send(32'd2, 32'd10, 1'b0, 1'b0);
      k = 0;
      while (n_stop < 1 && k < 200) begin @(posedge clk); k++; end
      #1;
      n_checks++;
      if (n_stop < 1) begin n_fail++; $display("FAIL restart_stop_timeout: got %0d stops required 1", n_stop); end
      send(32'd2, 32'd10, 1'b0, 1'b0);
      wait_idle("restart");
      n_checks += 7;
      if (n_loads != 4)    begin n_fail++; $display("FAIL restart_loads: got %0d required 4", n_loads); end
      if (load_q.size() != 4 || load_q[1] - load_q[0] != 10 || load_q[2] - load_q[1] != 10 || load_q[3] - load_q[2] != 10)
                           begin n_fail++; $display("FAIL restart_spacing: got %0d loads, required spacing 10,10,10", load_q.size()); end
      if (n_start != 2)    begin n_fail++; $display("FAIL restart_starts: got %0d required 2", n_start); end
      if (n_stop != 2)     begin n_fail++; $display("FAIL restart_stops: got %0d required 2", n_stop); end
      if (n_done != 2)     begin n_fail++; $display("FAIL restart_seg_done: got %0d required 2", n_done); end
      if (n_run_fall != 1) begin n_fail++; $display("FAIL restart_run_gap: got %0d run falls required 1", n_run_fall); end
      if (pos !== 32'd12)  begin n_fail++; $display("FAIL restart_pos: got %0d required 12", pos); end
   endtask

   initial begin
      clr_mon();
      test_reset();
      test_single();
      test_back_to_back();
      test_pause();
      test_abort();
      test_zero();
      test_restart();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
